bp_be_stride_detector: RTL and testbench

//  Producer side of the loop-count discovery handshake. Trains a small PC-indexed table on committed loads.

---
 rtl/bp_be_pkg.sv | 28 ++
 rtl/bp_be_stride_table.sv | 72 +++++++
 rtl/bp_be_stride_detector.sv | 128 ++++++++++++
 tb/tb_bp_be_stride_detector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride detector: FSM states, stride-table entry layout and
// a stride sign-extension helper.
package bp_be_pkg;

    localparam int unsigned vaddr_width_p  = 39;
    localparam int unsigned stride_width_p = 12;
    localparam int unsigned conf_width_p   = 2;

    typedef enum logic [1:0] {
        e_idle,
        e_discover,
        e_wait_cnt,
        e_prefetch
    } bp_be_stride_state_e;

    typedef struct packed {
        logic                      v;
        logic [vaddr_width_p-1:0]  tag;
        logic [vaddr_width_p-1:0]  last_addr;
        logic [stride_width_p-1:0] stride;
        logic [conf_width_p-1:0]   conf;
    } bp_be_stride_entry_s;

    function automatic logic [vaddr_width_p-1:0] sext_stride(input logic [stride_width_p-1:0] s);
        return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
    endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// Direct-mapped, PC-indexed stride table trained on committed loads; exports the post-update
// confidence of the trained entry and the fields of the locked entry.
module bp_be_stride_table
    import bp_be_pkg::*;
#(
    parameter int unsigned entries_p = 4,
    localparam int unsigned idx_width_lp = $clog2(entries_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      train_v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eaddr_i,
    input  logic                      lock_v_i,
    input  logic [idx_width_lp-1:0]   lock_idx_i,
    output logic                      upd_v_o,
    output logic [idx_width_lp-1:0]   upd_idx_o,
    output logic [conf_width_p-1:0]   upd_conf_o,
    output logic [vaddr_width_p-1:0]  locked_last_addr_o,
    output logic [stride_width_p-1:0] locked_stride_o,
    output logic [conf_width_p-1:0]   locked_conf_o
);

    bp_be_stride_entry_s tbl_q [entries_p];
    bp_be_stride_entry_s cur_entry, upd_entry;
    logic [vaddr_width_p-1:0] delta;
    logic hit, fits, match;

    assign upd_idx_o = pc_i[2 +: idx_width_lp];
    assign cur_entry = tbl_q[upd_idx_o];
    assign hit       = cur_entry.v && (cur_entry.tag == pc_i);
    assign delta     = eaddr_i - cur_entry.last_addr;
    // Delta fits when every bit above the stride sign bit matches it.
    assign fits      = (&delta[vaddr_width_p-1:stride_width_p-1])
                    || ~(|delta[vaddr_width_p-1:stride_width_p-1]);
    assign match     = fits && (delta != '0) && (delta[stride_width_p-1:0] == cur_entry.stride);

    always_comb begin
        upd_entry = cur_entry;
        upd_v_o   = 1'b0;
        if (train_v_i) begin
            if (hit) begin
                upd_v_o             = 1'b1;
                upd_entry.last_addr = eaddr_i;
                if (match) begin
                    if (cur_entry.conf != '1) upd_entry.conf = cur_entry.conf + 1'b1;
                end else begin
                    upd_entry.stride = fits ? delta[stride_width_p-1:0] : '0;
                    upd_entry.conf   = '0;
                end
            end else if (!(lock_v_i && (upd_idx_o == lock_idx_i))) begin
                // The locked entry must not be evicted while the detector is busy.
                upd_v_o   = 1'b1;
                upd_entry = '{v: 1'b1, tag: pc_i, last_addr: eaddr_i, stride: '0, conf: '0};
            end
        end
    end

    assign upd_conf_o         = upd_entry.conf;
    assign locked_last_addr_o = tbl_q[lock_idx_i].last_addr;
    assign locked_stride_o    = tbl_q[lock_idx_i].stride;
    assign locked_conf_o      = tbl_q[lock_idx_i].conf;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(entries_p); i++) tbl_q[i] <= '0;
        end else if (upd_v_o) begin
            tbl_q[upd_idx_o] <= upd_entry;
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Loop-count discovery producer: detects constant-stride committed loads, hands off to loop
// inference, then issues the accepted number of stride prefetches.
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter int unsigned entries_p        = 4,
    parameter int unsigned start_thresh_p   = 1,
    parameter int unsigned confirm_thresh_p = 3,
    parameter int unsigned output_range_p   = 8,
    parameter int unsigned max_pf_p         = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      commit_v_i,
    input  logic                      commit_load_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [vaddr_width_p-1:0]  commit_eaddr_i,
    output logic                      start_discovery_o,
    output logic                      confirm_discovery_o,
    output logic [vaddr_width_p-1:0]  striding_pc_o,
    input  logic [output_range_p-1:0] remaining_iter_i,
    input  logic                      v_i,
    output logic                      yumi_o,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_vaddr_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o
);

    localparam int unsigned idx_width_lp = $clog2(entries_p);
    localparam int unsigned cnt_width_lp = (output_range_p > $clog2(max_pf_p + 1))
                                         ? output_range_p : $clog2(max_pf_p + 1);

    bp_be_stride_state_e state_q, state_d;

    logic                      upd_v;
    logic [idx_width_lp-1:0]   upd_idx, lock_idx_q;
    logic [conf_width_p-1:0]   upd_conf, locked_conf;
    logic [vaddr_width_p-1:0]  locked_last_addr, pc_q, pf_addr_q;
    logic [stride_width_p-1:0] locked_stride, stride_q;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_in, iter_ext;

    bp_be_stride_table #(
        .entries_p(entries_p)
    ) table_u (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .train_v_i          (commit_v_i && commit_load_i),
        .pc_i               (commit_pc_i),
        .eaddr_i            (commit_eaddr_i),
        .lock_v_i           (state_q != e_idle),
        .lock_idx_i         (lock_idx_q),
        .upd_v_o            (upd_v),
        .upd_idx_o          (upd_idx),
        .upd_conf_o         (upd_conf),
        .locked_last_addr_o (locked_last_addr),
        .locked_stride_o    (locked_stride),
        .locked_conf_o      (locked_conf)
    );

    assign iter_ext = cnt_width_lp'(remaining_iter_i);
    assign cnt_in   = (iter_ext > cnt_width_lp'(max_pf_p)) ? cnt_width_lp'(max_pf_p) : iter_ext;

    always_comb begin
        state_d           = state_q;
        start_discovery_o = 1'b0;
        yumi_o            = 1'b0;
        unique case (state_q)
            e_idle: begin
                if (upd_v && (upd_conf >= conf_width_p'(start_thresh_p))) begin
                    start_discovery_o = 1'b1;
                    state_d           = e_discover;
                end
            end
            e_discover: begin
                if (locked_conf >= conf_width_p'(confirm_thresh_p)) state_d = e_wait_cnt;
                else if (locked_conf == '0)                        state_d = e_idle;
            end
            e_wait_cnt: begin
                if (v_i) begin
                    yumi_o  = 1'b1;
                    state_d = (cnt_in == '0) ? e_idle : e_prefetch;
                end
            end
            e_prefetch: begin
                if (pf_ready_and_i && (cnt_q == cnt_width_lp'(1))) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
        if (reset_i) begin
            start_discovery_o = 1'b0;
            yumi_o            = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            lock_idx_q <= '0;
            pc_q       <= '0;
            pf_addr_q  <= '0;
            stride_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_discovery_o) begin
                lock_idx_q <= upd_idx;
                pc_q       <= commit_pc_i;
            end
            // Stride is captured at hand-off so later training cannot disturb the prefetch walk.
            if (yumi_o) begin
                cnt_q     <= cnt_in;
                stride_q  <= locked_stride;
                pf_addr_q <= locked_last_addr + sext_stride(locked_stride);
            end else if (pf_v_o && pf_ready_and_i) begin
                cnt_q     <= cnt_q - 1'b1;
                pf_addr_q <= pf_addr_q + sext_stride(stride_q);
            end
        end
    end

    assign confirm_discovery_o = (state_q == e_wait_cnt);
    assign pf_v_o              = (state_q == e_prefetch);
    assign busy_o              = (state_q != e_idle);
    assign striding_pc_o       = pc_q;
    assign pf_vaddr_o          = pf_addr_q;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Scoreboard bench for the stride detector: stimulus queues expected output events, a negedge
// monitor pops and compares them as the DUT produces them.
module tb_bp_be_stride_detector;

    localparam int unsigned V = 39;

    typedef enum int {EvStart, EvConfirm, EvYumi, EvPf} ev_kind_e;
    typedef struct {
        ev_kind_e         kind;
        logic [V-1:0]     val;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         commit_v_i, commit_load_i;
    logic [V-1:0] commit_pc_i, commit_eaddr_i;
    logic         start_discovery_o, confirm_discovery_o;
    logic [V-1:0] striding_pc_o;
    logic [7:0]   remaining_iter_i;
    logic         v_i, yumi_o;
    logic         pf_v_o;
    logic [V-1:0] pf_vaddr_o;
    logic         pf_ready_and_i;
    logic         busy_o;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];
    logic prev_confirm = 1'b0;

    always #5 clk = ~clk;

    bp_be_stride_detector dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .commit_v_i          (commit_v_i),
        .commit_load_i       (commit_load_i),
        .commit_pc_i         (commit_pc_i),
        .commit_eaddr_i      (commit_eaddr_i),
        .start_discovery_o   (start_discovery_o),
        .confirm_discovery_o (confirm_discovery_o),
        .striding_pc_o       (striding_pc_o),
        .remaining_iter_i    (remaining_iter_i),
        .v_i                 (v_i),
        .yumi_o              (yumi_o),
        .pf_v_o              (pf_v_o),
        .pf_vaddr_o          (pf_vaddr_o),
        .pf_ready_and_i      (pf_ready_and_i),
        .busy_o              (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic [V-1:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [V-1:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %h, expected no event", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d val %h, expected kind %0d val %h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: one event per DUT handshake/pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (reset_i) begin
            prev_confirm <= 1'b0;
        end else begin
            if (confirm_discovery_o && !prev_confirm) observe(EvConfirm, striding_pc_o);
            if (yumi_o)                               observe(EvYumi, '0);
            if (pf_v_o && pf_ready_and_i)             observe(EvPf, pf_vaddr_o);
            if (start_discovery_o)                    observe(EvStart, commit_pc_i);
            prev_confirm <= confirm_discovery_o;
        end
    end

    task automatic commit(input logic [V-1:0] pc, input logic [V-1:0] ea);
        commit_v_i     = 1'b1;
        commit_load_i  = 1'b1;
        commit_pc_i    = pc;
        commit_eaddr_i = ea;
        @(posedge clk);
        #1;
        commit_v_i     = 1'b0;
    endtask

    // Five trains from a fresh (or just-broken) entry: start on the 3rd, conf saturates on the 5th.
    task automatic train5(input logic [V-1:0] pc, input longint base, input longint step);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) push(EvStart, pc);
            if (k == 4) push(EvConfirm, pc);
            commit(pc, V'(base + step * k));
        end
    endtask

    task automatic wait_confirm(input string name);
        for (int i = 0; i < 20; i++) begin
            if (confirm_discovery_o) break;
            @(posedge clk);
            #1;
        end
        check(name, confirm_discovery_o, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy_o) break;
            @(posedge clk);
            #1;
        end
        check(name, busy_o, 0);
    endtask

    task automatic give_count(input logic [7:0] n);
        v_i              = 1'b1;
        remaining_iter_i = n;
        @(posedge clk);
        #1;
        v_i              = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        commit_v_i = 1'b0;
        commit_load_i = 1'b0;
        commit_pc_i = '0;
        commit_eaddr_i = '0;
        v_i = 1'b0;
        remaining_iter_i = '0;
        pf_ready_and_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;

        check("rst_busy",    busy_o, 0);
        check("rst_confirm", confirm_discovery_o, 0);
        check("rst_pf_v",    pf_v_o, 0);
        check("rst_pf_addr", pf_vaddr_o, 0);
        check("rst_pc",      striding_pc_o, 0);

        // Positive stride, pc 0x100
        commit(39'h100, 39'h1000);
        commit(39'h100, 39'h1008);
        push(EvStart, 39'h100);
        commit(39'h100, 39'h1010);
        check("t1_striding_pc", striding_pc_o, 39'h100);
        check("t1_busy", busy_o, 1);
        push(EvConfirm, 39'h100);
        commit(39'h100, 39'h1018);
        commit(39'h100, 39'h1020);
        wait_confirm("t1_confirm");

        push(EvYumi, '0);
        push(EvPf, 39'h1028);
        push(EvPf, 39'h1030);
        push(EvPf, 39'h1038);
        give_count(8'd3);
        check("t2_confirm_drop", confirm_discovery_o, 0);
        wait_idle("t2_idle");
        check("t2_q_empty", exp_q.size(), 0);

        // Negative stride, pc 0x204
        train5(39'h204, 64'h2000, -64'sd16);
        wait_confirm("t3_confirm");
        push(EvYumi, '0);
        push(EvPf, 39'h1FB0);
        push(EvPf, 39'h1FA0);
        give_count(8'd2);
        wait_idle("t3_idle");
        check("t3_q_empty", exp_q.size(), 0);

        // Stride break during discovery, pc 0x108
        commit(39'h108, 39'h1000);
        commit(39'h108, 39'h1008);
        push(EvStart, 39'h108);
        commit(39'h108, 39'h1010);
        commit(39'h108, 39'h5000);
        repeat (4) @(posedge clk);
        #1;
        check("t4_break_idle", busy_o, 0);
        check("t4_no_confirm", confirm_discovery_o, 0);
        check("t4_q_empty", exp_q.size(), 0);
        train5(39'h108, 64'h5000, 64'sd8);
        wait_confirm("t4_confirm");

        // Zero count
        push(EvYumi, '0);
        give_count(8'd0);
        check("t5_zero_pf_v", pf_v_o, 0);
        check("t5_zero_idle", busy_o, 0);
        check("t5_zero_q_empty", exp_q.size(), 0);

        // Count capped at 16, with a 5-cycle sink stall
        train5(39'h10C, 64'h3000, 64'sd8);
        wait_confirm("t5_confirm");
        push(EvYumi, '0);
        for (int k = 0; k < 16; k++) push(EvPf, V'(64'h3028 + 8 * k));
        pf_ready_and_i = 1'b0;
        give_count(8'd200);
        for (int i = 0; i < 5; i++) begin
            check("t5_stall_v", pf_v_o, 1);
            check("t5_stall_addr", pf_vaddr_o, 39'h3028);
            @(posedge clk);
            #1;
        end
        pf_ready_and_i = 1'b1;
        wait_idle("t5_cap_idle");
        check("t5_cap_q_empty", exp_q.size(), 0);

        // Reset during prefetch
        train5(39'h100, 64'h7000, 64'sd8);
        wait_confirm("t6_confirm");
        push(EvYumi, '0);
        pf_ready_and_i = 1'b0;
        give_count(8'd10);
        check("t6_in_pf", pf_v_o, 1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        pf_ready_and_i = 1'b1;
        check("t6_pf_v",    pf_v_o, 0);
        check("t6_confirm", confirm_discovery_o, 0);
        check("t6_busy",    busy_o, 0);
        check("t6_pf_addr", pf_vaddr_o, 0);
        commit(39'h100, 39'h7028);
        commit(39'h100, 39'h7030);
        push(EvStart, 39'h100);
        commit(39'h100, 39'h7038);
        repeat (2) @(posedge clk);
        #1;
        check("t6_restart_busy", busy_o, 1);
        check("t6_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
